// File: rtl/de270_mul_pkg.sv
// Shared encodings for the DE270 shared-multiplier arbiter: op codes, FSM states
// and the number of partial-product issue cycles.
package de270_mul_pkg;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXUU = 2'b01;
   localparam logic [1:0] OP_MULXSU = 2'b10;
   localparam logic [1:0] OP_MULXSS = 2'b11;

   localparam int ISSUE_CYCLES = 4;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIX,
      RESP
   } state_t;

endpackage

// File: rtl/de270_mul16_reg.sv
// 16x16 unsigned multiplier with a single output register; one cycle of latency.
module de270_mul16_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   always_ff @(posedge clk) begin
      if (reset) p <= '0;
      else       p <= a * b;
   end

endmodule

// File: rtl/de270_mul_arbiter.sv
// Round-robin arbiter sharing one 16x16 multiplier cell; each 32x32 multiply is four
// partial products accumulated to 64 bits, then sign-corrected into a one-hot response.
//
//   state | meaning
//   IDLE  | grant offered to next valid requester at/after rr_ptr
//   ISSUE | four partial products issued, cnt_q counts down 3..0
//   DRAIN | last product lands in the accumulator
//   FIX   | select low/high word and apply signed correction into resp_q
//   RESP  | one-cycle resp_valid to the latched requester
module de270_mul_arbiter
   import de270_mul_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_a,
   input  logic [NUM_REQ*32-1:0]  req_b,
   input  logic [NUM_REQ*2-1:0]   req_op,
   output logic [NUM_REQ-1:0]     resp_valid,
   output logic [31:0]            resp_data,
   output logic                   busy
);

   state_t             state_q, state_d;
   logic [1:0]         cnt_q;
   logic [1:0]         issue_idx;
   logic [PTR_W-1:0]   rr_ptr, rr_next, grant_idx, cand, sel_q;
   logic               grant_any, accept;
   logic [31:0]        a_q, b_q, sel_a, sel_b;
   logic [1:0]         op_q, sel_op;
   logic [63:0]        acc;
   logic [5:0]         sh_q, sh_d;
   logic               add_q;
   logic [15:0]        mul_a, mul_b;
   logic [31:0]        prod;
   logic [31:0]        resp_q, fix_d, hi, corr_a, corr_b;

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign accept    = (state_q == IDLE) && !reset && grant_any;
   assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
   assign rr_next   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == PTR_W'(k)) begin
            sel_a  = req_a[32*k +: 32];
            sel_b  = req_b[32*k +: 32];
            sel_op = req_op[2*k +: 2];
         end
      end
   end

   // The down-counter runs 3..0, so partial-product order is its complement.
   assign issue_idx = 2'(ISSUE_CYCLES - 1) - cnt_q;

   always_comb begin
      mul_a = a_q[15:0];
      mul_b = b_q[15:0];
      sh_d  = 6'd0;
      case (issue_idx)
         2'd1:    begin mul_a = a_q[31:16]; mul_b = b_q[15:0];  sh_d = 6'd16; end
         2'd2:    begin mul_a = a_q[15:0];  mul_b = b_q[31:16]; sh_d = 6'd16; end
         2'd3:    begin mul_a = a_q[31:16]; mul_b = b_q[31:16]; sh_d = 6'd32; end
         default: ;
      endcase
   end

   de270_mul16_reg u_mul (
      .clk   (clk),
      .reset (reset),
      .a     (mul_a),
      .b     (mul_b),
      .p     (prod)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   if (cnt_q == 2'd0) state_d = DRAIN;
         DRAIN:   state_d = FIX;
         FIX:     state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Signed results are the unsigned high word minus the two's-complement cross terms.
   assign hi     = acc[63:32];
   assign corr_a = a_q[31] ? b_q : 32'd0;
   assign corr_b = b_q[31] ? a_q : 32'd0;

   always_comb begin
      case (op_q)
         OP_MUL:    fix_d = acc[31:0];
         OP_MULXUU: fix_d = hi;
         OP_MULXSU: fix_d = hi - corr_a;
         default:   fix_d = hi - corr_a - corr_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         sel_q  <= '0;
         rr_ptr <= '0;
         acc    <= '0;
         cnt_q  <= '0;
         sh_q   <= '0;
         add_q  <= 1'b0;
         resp_q <= '0;
      end else begin
         add_q <= (state_q == ISSUE);
         sh_q  <= sh_d;
         if (accept) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            op_q   <= sel_op;
            sel_q  <= grant_idx;
            rr_ptr <= rr_next;
            acc    <= '0;
            cnt_q  <= 2'(ISSUE_CYCLES - 1);
         end else if (add_q) begin
            acc <= acc + ({32'd0, prod} << sh_q);
         end
         if (state_q == ISSUE && cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
         if (state_q == FIX) resp_q <= fix_d;
      end
   end

   assign resp_valid = (state_q == RESP && !reset) ? (NUM_REQ'(1) << sel_q) : '0;
   assign resp_data  = resp_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_de270_mul_arbiter.sv
// Bench for de270_mul_arbiter: cycle-level reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_de270_mul_arbiter;

   localparam int N = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N*32-1:0]   req_a = '0;
   logic [N*32-1:0]   req_b = '0;
   logic [N*2-1:0]    req_op = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      resp_valid;
   logic [31:0]       resp_data;
   logic              busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int          m_ptr = 0;
   int          m_free = 0;
   bit          m_pend = 1'b0;
   int          m_resp_cyc = 0;
   int          m_resp_idx = 0;
   logic [31:0] m_resp_data = '0;

   de270_mul_arbiter #(.NUM_REQ(N), .PTR_W(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
      logic [63:0] ea, eb, p;
      ea = op[1] ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      logic [N-1:0] s;
      for (int k = 0; k < N; k++) begin
         s = v >> ((ptr + k) % N);
         if (s[0]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // Reference model: free/busy windows, round-robin pointer, one pending response.
   initial begin
      logic [N-1:0]    exp_ready, exp_rv;
      logic [N*32-1:0] ta, tb;
      logic [N*2-1:0]  to;
      int              j;
      bit              idle;
      forever begin
         @(negedge clk);
         cyc++;
         idle      = (cyc >= m_free);
         j         = rr_pick(req_valid, m_ptr);
         exp_ready = (reset || !idle || j < 0) ? '0 : (N'(1) << j);
         exp_rv    = (!reset && m_pend && cyc == m_resp_cyc) ? (N'(1) << m_resp_idx) : '0;
         check("req_ready", 64'(req_ready), 64'(exp_ready));
         check("resp_valid", 64'(resp_valid), 64'(exp_rv));
         check("busy", 64'(busy), 64'(!idle));
         if (exp_rv != '0) check("resp_data", 64'(resp_data), 64'(m_resp_data));
         if (m_pend && cyc == m_resp_cyc) m_pend = 1'b0;
         if (reset) begin
            m_pend = 1'b0;
            m_free = cyc + 1;
            m_ptr  = 0;
         end else if (exp_ready != '0) begin
            ta = req_a >> (32 * j);
            tb = req_b >> (32 * j);
            to = req_op >> (2 * j);
            m_pend      = 1'b1;
            m_resp_cyc  = cyc + 7;
            m_resp_idx  = j;
            m_free      = cyc + 8;
            m_ptr       = (j + 1) % N;
            m_resp_data = ref_mul(ta[31:0], tb[31:0], to[1:0]);
         end
      end
   end

   task automatic put(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [N*32-1:0] m32;
      logic [N*2-1:0]  m2;
      m32    = {{(N*32-32){1'b0}}, 32'hFFFF_FFFF} << (32 * r);
      m2     = {{(N*2-2){1'b0}}, 2'b11} << (2 * r);
      req_a  = (req_a & ~m32) | ({{(N*32-32){1'b0}}, a} << (32 * r));
      req_b  = (req_b & ~m32) | ({{(N*32-32){1'b0}}, b} << (32 * r));
      req_op = (req_op & ~m2) | ({{(N*2-2){1'b0}}, op} << (2 * r));
   endtask

   // Waits (bounded) for any accept; returns the grant vector and negedges waited.
   task automatic wait_accept(output logic [N-1:0] got, output int waited);
      got    = '0;
      waited = 0;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk); #1;
         if ((req_ready & req_valid) != '0) begin
            got    = req_ready;
            waited = t;
            break;
         end
      end
      if (got == '0) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no grant within 40 cycles, required one at t=%0t", $time);
      end
   endtask

   task automatic run_op(input string name, input int r, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, output int waited);
      logic [N-1:0] got;
      put(r, op, a, b);
      req_valid = req_valid | (N'(1) << r);
      wait_accept(got, waited);
      check({name, "_grant"}, 64'(got), 64'(N'(1) << r));
      @(posedge clk); #1;
      req_valid = req_valid & ~(N'(1) << r);
      repeat (7) @(negedge clk);
      #1;
      check({name, "_rv"}, 64'(resp_valid), 64'(N'(1) << r));
      check({name, "_data"}, 64'(resp_data), 64'(exp));
   endtask

   initial begin
      int           w;
      logic [N-1:0] got, acc_mask;

      check("model_mul", 64'(ref_mul(32'd3, 32'd5, 2'b00)), 64'h0000_000F);
      check("model_xuu", 64'(ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01)), 64'hFFFF_FFFE);
      check("model_xss", 64'(ref_mul(32'h8000_0000, 32'd2, 2'b11)), 64'hFFFF_FFFF);

      // Reset state with every requester asserting.
      put(0, 2'b00, 32'd1, 32'd1);
      req_valid = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_rv", 64'(resp_valid), 64'h0);
      check("rst_data", 64'(resp_data), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      @(posedge clk); #1;
      req_valid = '0;
      reset     = 1'b0;
      @(posedge clk); #1;

      run_op("mul3x5", 0, 2'b00, 32'd3, 32'd5, 32'h0000_000F, w);
      @(negedge clk); #1;
      check("after_busy", 64'(busy), 64'h0);
      check("hold_data", 64'(resp_data), 64'h0000_000F);
      @(posedge clk); #1;

      run_op("xuu_ff", 1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, w);
      run_op("mul_ff", 1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, w);
      check("b2b_gap", 64'(w), 64'd1);
      run_op("xss_ff", 2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, w);
      run_op("xsu_m1x2", 2, 2'b10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, w);
      run_op("xss_min", 2, 2'b11, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, w);
      run_op("xsu_minxff", 3, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, w);
      run_op("wrap_r3", 3, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, w);
      check("wrap_gap", 64'(w), 64'd1);

      // Abort mid-operation: reset during the third cycle after accept.
      put(1, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      req_valid = 4'b0010;
      wait_accept(got, w);
      check("abort_grant", 64'(got), 64'h2);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      put(1, 2'b00, 32'd7, 32'd6);
      put(2, 2'b00, 32'd9, 32'd9);
      req_valid = 4'b0110;
      @(negedge clk); #1;
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_ptr0", 64'(req_ready), 64'h2);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (3) @(negedge clk);
      #1;
      check("abort_no_rv", 64'(resp_valid), 64'h0);
      repeat (4) @(negedge clk);
      #1;
      check("post_abort_rv", 64'(resp_valid), 64'h2);
      check("post_abort_data", 64'(resp_data), 64'd42);
      @(posedge clk); #1;

      // Round-robin under continuous demand, from a fresh pointer.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int r = 0; r < N; r++) put(r, 2'(r), 32'h1000_0001 * (r + 1), 32'hF0F0_0F0F + r);
      req_valid = 4'hF;
      for (int n = 0; n < 5; n++) begin
         wait_accept(got, w);
         check("rr_order", 64'(got), 64'(N'(1) << (n % N)));
         if (n > 0) check("rr_gap", 64'(w), 64'd8);
      end
      @(posedge clk); #1;
      req_valid = '0;
      repeat (10) @(posedge clk);
      #1;

      // Random traffic with skips and occasional resets; the model checks every cycle.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk); #1;
         acc_mask = req_valid & req_ready;
         @(posedge clk); #1;
         reset = ($urandom_range(0, 399) == 0);
         for (int r = 0; r < N; r++) begin
            if (acc_mask[r]) begin
               req_valid[r] = 1'b0;
            end else if (req_valid[r]) begin
               if ($urandom_range(0, 31) == 0) req_valid[r] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               put(r, 2'($urandom_range(0, 3)), $urandom, $urandom);
               req_valid[r] = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = '0;
      repeat (12) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/de270_mul_arbiter.md
Name: de270_mul_arbiter

Overview:
- Shares one registered 16x16 unsigned multiplier cell among NUM_REQ requesters, such as CPU custom-instruction ports and DMA/filter engines on DE270.
- Round-robin arbitration selects one request at a time.
- Each 32x32 multiply is sequenced as four 16-bit partial products and accumulated into a 64-bit result.
- Signed high-word correction is applied before a one-hot, single-cycle response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PTR_W, 2, width of the round-robin pointer (clog2(NUM_REQ)).

Ports:
- clk  in  1  system clock; every flop is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request strobe; held until accepted.
- req_ready  out  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i].
- req_a  in  NUM_REQ*32  operand A, requester i at [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B, same packing as req_a.
- req_op  in  NUM_REQ*2  per-requester op: 00 MUL (low 32), 01 MULXUU, 10 MULXSU (A signed, B unsigned), 11 MULXSS (high 32 in all three).
- resp_valid  out  NUM_REQ  one-hot, single-cycle result strobe; no backpressure.
- resp_data  out  32  result; valid only while resp_valid is nonzero.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_data=0, busy=0, state=IDLE, rr_ptr=0, accumulator=0.
- States: IDLE -> ISSUE (4 cycles, idx 0..3) -> DRAIN (1) -> FIX (1) -> RESP (1) -> IDLE.
- IDLE, grant:
  - req_ready is combinational and only nonzero in IDLE.
  - It is one-hot for the first i at or after rr_ptr (wrapping modulo NUM_REQ) with req_valid[i]=1.
  - It is all-zero if no requests are pending.
- IDLE, on accept at cycle T: latch A, B, op and the requester index; clear the accumulator; rr_ptr <= (i+1) mod NUM_REQ.
- ISSUE, T+1..T+4: multiplier operands per idx:
  - idx 0: A[15:0]*B[15:0], shift 0.
  - idx 1: A[31:16]*B[15:0], shift 16.
  - idx 2: A[15:0]*B[31:16], shift 16.
  - idx 3: A[31:16]*B[31:16], shift 32.
- Multiplier cell latency is exactly 1 cycle. The product issued at cycle k is added, shifted, into the 64-bit accumulator at cycle k+1 (T+2..T+5). DRAIN absorbs the last add.
- FIX, T+6: resp_data register <=
  - op 00: acc[31:0].
  - op 01: acc[63:32].
  - op 10: acc[63:32] - (A[31] ? B : 0).
  - op 11: acc[63:32] - (A[31] ? B : 0) - (B[31] ? A : 0).
  - All subtraction is modulo 2^32.
- RESP, T+7: resp_valid[latched index]=1 for exactly one cycle; resp_data holds its value until the next FIX.
- Throughput: the earliest next accept is at T+8.
- Fixed latency: 7 cycles from accept to resp_valid.
- Requests arriving while busy wait; they are never dropped, and req_ready stays 0.
- A requester that deasserts req_valid before being granted is simply skipped.
- Reset asserted in any state aborts the operation: no resp_valid is produced, and all registers return to their reset values on the next edge.
- Single requester: back-to-back accepts every 8 cycles, and rr_ptr wraps correctly.

Decomposition:
- Package de270_mul_pkg holds:
  - op encodings OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS;
  - state enum IDLE/ISSUE/DRAIN/FIX/RESP;
  - ISSUE_CYCLES=4.
- Sub-module de270_mul16_reg:
  - 16x16 unsigned multiplier, 32-bit product registered once, synchronous active-high reset clears it;
  - a DSP block must be inferred.
- The arbiter, FSM, accumulator and correction logic live in the top module.

Test Plan:
- Req0, MUL, A=3, B=5, accepted at T -> resp_valid=4'b0001 at T+7 only, resp_data=0x0000000F; busy high T+1..T+7.
- Req1, MULXUU, A=B=0xFFFFFFFF -> resp_data=0xFFFFFFFE; the same operands with MUL -> 0x00000001.
- Req2, MULXSS, A=B=0xFFFFFFFF -> 0x00000000; MULXSU, A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF; MULXSS, A=0x80000000, B=2 -> 0xFFFFFFFF.
- All four requesters hold req_valid continuously -> grant order 0,1,2,3,0 at accepts T, T+8, T+16, T+24, T+32; each resp_valid bit matches its grant.
- Reset pulsed for 1 cycle at T+3 of an operation -> no resp_valid ever fires for it; busy=0 and rr_ptr=0 next cycle; a new request is accepted immediately after.
- Random operands and ops (10k ops, random req_valid) against a 64-bit reference model -> every result matches; no request is lost or duplicated; at most one bit of req_ready/resp_valid is high.
